audio_clk_supervisor: RTL and testbench
=======================================

// Module: audio_clk_supervisor
// PURPOSE
//  Sequences the 50 MHz -> 3.125 MHz audio codec PLL.
//  - Holds the PLL in reset at power-up.
//  - Waits for a qualified lock, then releases the codec-domain reset request.
//  - On lock loss: re-resets the PLL and counts the event.
//  - After repeated lock timeouts: stops in FAULT until software restarts it.
//  Runs entirely on the free-running reference clock, in front of the PLL wrapper.
// PARAMETERS
//  RST_CYCLES     16     PLL reset pulse width, refclk cycles (>=2)
//  LOCK_TIMEOUT   65536  max cycles from PLL reset release to qualified lock (~1.3 ms)
//  STABLE_CYCLES  1024   cycles locked must stay continuously high to qualify
//  MAX_RETRIES    3      consecutive lock timeouts before FAULT (>=1)
//  CNT_W          17     timer width; must hold max(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES)
// PORTS
//  refclk       in   1  50 MHz reference clock, free-running
//  rst_n        in   1  asynchronous active-low reset
//  pll_locked   in   1  PLL locked, asynchronous to refclk
//  restart      in   1  single-cycle pulse, refclk domain; forces a full re-sequence
//  pll_rst      out  1  active-high reset to the PLL
//  codec_rst_n  out  1  active-low reset request for the codec domain
//  clk_ok       out  1  audio clock qualified and running
//  fault        out  1  retry budget exhausted
//  state        out  3  current FSM state code
//  loss_count   out  8  number of lock-loss events while in RUN; saturates at 255
// BEHAVIOUR
//  Reset values (rst_n low):
//  - pll_rst=1, codec_rst_n=0, clk_ok=0, fault=0, state=PLL_RST, loss_count=0.
//  - Timer, stable counter and retry counter all = 0.
//  pll_locked passes through a 2-flop synchronizer (locked_s), giving 2 cycles of latency.
//  Outputs are registered and decoded from the next state, so they change on the same edge as state:
//  - pll_rst=1 in PLL_RST and FAULT.
//  - codec_rst_n=1 and clk_ok=1 only in RUN.
//  - fault=1 only in FAULT.
//  States (code):
//  - PLL_RST(0): hold for exactly RST_CYCLES cycles. Then go to WAIT_LOCK; the lock timer clears on entry.
//  - WAIT_LOCK(1):
//    - locked_s=1 -> STABLE, stable counter = 0.
//    - Lock timer reaches LOCK_TIMEOUT-1 -> retry+1; if retry+1 == MAX_RETRIES -> FAULT, else -> PLL_RST.
//  - STABLE(2):
//    - Each cycle with locked_s=1: stable counter +1. At STABLE_CYCLES-1 -> RUN, and retry clears.
//    - locked_s=0 -> WAIT_LOCK; the stable counter clears but the lock timer does NOT.
//      A chattering lock therefore still times out.
//  - RUN(3): locked_s=0 -> PLL_RST and loss_count+1 (saturating). codec_rst_n falls on the same edge.
//  - FAULT(4): terminal. Only restart or rst_n leaves it.
//  restart=1 in any state -> PLL_RST on the next edge. It clears retry, both counters and the timer.
//  loss_count is not cleared by restart; only rst_n clears it.
//  Priority when events coincide in one cycle:
//  - restart > lock event > timeout.
//  - In WAIT_LOCK, locked_s=1 wins over timeout.
//  - In STABLE, completing qualification wins over timeout.
//  Reset mid-operation: rst_n low forces the reset values asynchronously, from any state.
//  Unused state codes (5..7) -> PLL_RST.
// STRUCTURE
//  Shared package audio_clk_pkg:
//  - State codes ST_PLL_RST..ST_FAULT and the state width.
//  - Default timing constants, so the clock-status CSR decoder uses the same state codes.
//  One sub-module: sync_2ff (generic bit synchronizer, async active-low reset, resets to 0), used for pll_locked.
//  Everything else (FSM, CNT_W timer, stable counter, retry and loss counters) lives in this module.
// TESTING
//  Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=8, MAX_RETRIES=2.
//  1 Bring-up:
//    - Release rst_n; pll_rst stays high for 4 cycles.
//    - Raise pll_locked 10 cycles later.
//    - Required: codec_rst_n=clk_ok=1 exactly 10 edges after the first edge that samples pll_locked high.
//    - Required: state=3.
//  2 Lock loss:
//    - In RUN, drop pll_locked for 5 cycles.
//    - Required: clk_ok falls 3 edges after the drop, pll_rst=1 for 4 cycles, loss_count=1.
//    - Required: after lock returns, RUN is re-entered.
//  3 Timeout to FAULT:
//    - Keep pll_locked=0.
//    - Required: two timeouts of 64 cycles, separated by a 4-cycle pll_rst pulse.
//    - Required: then fault=1, state=4, pll_rst=1 held for 1000 cycles.
//    - Then pulse restart. Required: fault=0, state=0, retry budget restored.
//  4 Chatter:
//    - In STABLE, toggle pll_locked every 5 cycles.
//    - Required: never reaches RUN; times out 64 cycles after WAIT_LOCK was first entered.
//  5 Saturation and priority:
//    - Force 300 lock losses. Required: loss_count=255.
//    - Pulse restart in the same cycle locked_s rises in WAIT_LOCK. Required: next state=0.
//  6 Async reset in RUN:
//    - Assert rst_n mid-cycle.
//    - Required: all outputs reach their reset values before the next edge, and loss_count=0.

Source files
------------

// File: rtl/audio_clk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : audio_clk_pkg                                                |
// | Description : State codes and default timing constants shared by the audio |
// |               PLL supervisor and the clock-status CSR decoder.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package audio_clk_pkg;

    localparam int STATE_W = 3;
    localparam int LOSS_W  = 8;

    // Codes are software-visible through the status CSR; keep them fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } clk_state_t;

    // Defaults for a 50 MHz reference clock.
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 17;

    // Bits needed for a retry counter that must be able to hold MAX_RETRIES.
    function automatic int retry_width(input int max_retries);
        return $clog2(max_retries + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_2ff                                                     |
// | Description : Generic two-flop bit synchronizer, async active-low reset,   |
// |               resets to 0.                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule
`default_nettype wire

// File: rtl/audio_clk_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_clk_supervisor                                         |
// | Description : Sequences the audio codec PLL: reset pulse, qualified lock,  |
// |               codec reset release, lock-loss recovery and retry-limited    |
// |               fault handling. Runs on the free-running reference clock.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module audio_clk_supervisor
    import audio_clk_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               codec_rst_n,
    output logic               clk_ok,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [LOSS_W-1:0]  loss_count
);

    localparam int RETRY_W = retry_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_MAX     = '1;

    logic locked_s;

    clk_state_t         state_q,  state_d;
    logic [CNT_W-1:0]   timer_q,  timer_d;
    logic [CNT_W-1:0]   stable_q, stable_d;
    logic [RETRY_W-1:0] retry_q,  retry_d;
    logic [LOSS_W-1:0]  loss_q,   loss_d;

    logic [CNT_W-1:0]   timer_inc;
    logic [CNT_W-1:0]   stable_inc;
    logic [RETRY_W-1:0] retry_inc;
    logic               timed_out;

    logic pll_rst_q;
    logic codec_rst_n_q;
    logic clk_ok_q;
    logic fault_q;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    assign timer_inc  = timer_q + 1'b1;
    assign stable_inc = stable_q + 1'b1;
    assign retry_inc  = retry_q + 1'b1;
    // Greater-or-equal so a lock drop on the last timer cycle still times out
    // one cycle later instead of letting the timer run past the limit.
    assign timed_out  = (timer_q >= TIMEOUT_LAST);

    // Next-state and counter update; restart outranks lock events, which outrank timeouts.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        stable_d = stable_q;
        retry_d  = retry_q;
        loss_d   = loss_q;

        if (restart) begin
            state_d  = ST_PLL_RST;
            timer_d  = '0;
            stable_d = '0;
            retry_d  = '0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (timer_q >= RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end

                ST_WAIT_LOCK: begin
                    timer_d = timer_inc;
                    if (locked_s) begin
                        state_d  = ST_STABLE;
                        stable_d = '0;
                    end else if (timed_out) begin
                        retry_d  = retry_inc;
                        timer_d  = '0;
                        stable_d = '0;
                        state_d  = (retry_inc >= RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
                    end
                end

                ST_STABLE: begin
                    // Lock timer keeps running so a chattering lock still times out.
                    timer_d = timer_inc;
                    if (!locked_s) begin
                        state_d  = ST_WAIT_LOCK;
                        stable_d = '0;
                    end else if (stable_inc >= STABLE_LAST) begin
                        state_d  = ST_RUN;
                        stable_d = stable_inc;
                        retry_d  = '0;
                    end else if (timed_out) begin
                        retry_d  = retry_inc;
                        timer_d  = '0;
                        stable_d = '0;
                        state_d  = (retry_inc >= RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
                    end else begin
                        stable_d = stable_inc;
                    end
                end

                ST_RUN: begin
                    if (!locked_s) begin
                        state_d  = ST_PLL_RST;
                        timer_d  = '0;
                        stable_d = '0;
                        if (loss_q != LOSS_MAX) begin
                            loss_d = loss_q + 1'b1;
                        end
                    end
                end

                ST_FAULT: begin
                    state_d = ST_FAULT;
                end

                default: begin
                    state_d  = ST_PLL_RST;
                    timer_d  = '0;
                    stable_d = '0;
                end
            endcase
        end
    end

    // State, counters and outputs; outputs decode the next state so they switch with it.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PLL_RST;
            timer_q       <= '0;
            stable_q      <= '0;
            retry_q       <= '0;
            loss_q        <= '0;
            pll_rst_q     <= 1'b1;
            codec_rst_n_q <= 1'b0;
            clk_ok_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            stable_q      <= stable_d;
            retry_q       <= retry_d;
            loss_q        <= loss_d;
            pll_rst_q     <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
            codec_rst_n_q <= (state_d == ST_RUN);
            clk_ok_q      <= (state_d == ST_RUN);
            fault_q       <= (state_d == ST_FAULT);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign codec_rst_n = codec_rst_n_q;
    assign clk_ok      = clk_ok_q;
    assign fault       = fault_q;
    assign state       = state_q;
    assign loss_count  = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_clk_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_audio_clk_supervisor                                      |
// | Description : Self-checking bench for audio_clk_supervisor with a         |
// |               time-stamp based reference model of the sequencing rules.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_audio_clk_supervisor;

    localparam int RST_C = 4;
    localparam int TO    = 64;
    localparam int STB   = 8;
    localparam int MR    = 2;
    localparam logic [14:0] RESET_VEC = 15'h4000;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       codec_rst_n;
    logic       clk_ok;
    logic       fault;
    logic [2:0] state;
    logic [7:0] loss_count;
    logic [14:0] obs;

    int errors = 0;
    int checks = 0;

    // Reference model: modes 0..4, absolute edge numbers and lock run-lengths.
    int m_mode, m_cyc, m_rst_enter, m_wait_start, m_run, m_fails, m_losses;
    bit m_s1, m_s2;

    audio_clk_supervisor #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .MAX_RETRIES   (MR),
        .CNT_W         (17)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .restart     (restart),
        .pll_rst     (pll_rst),
        .codec_rst_n (codec_rst_n),
        .clk_ok      (clk_ok),
        .fault       (fault),
        .state       (state),
        .loss_count  (loss_count)
    );

    always #10 refclk = ~refclk;

    assign obs = {pll_rst, codec_rst_n, clk_ok, fault, state, loss_count};

    function automatic void model_reset();
        m_mode = 0; m_cyc = 0; m_rst_enter = 0; m_wait_start = 0;
        m_run = 0; m_fails = 0; m_losses = 0; m_s1 = 0; m_s2 = 0;
    endfunction

    function automatic void model_step();
        int n;
        bit ls;
        bit expired;
        m_cyc++;
        n = m_cyc;
        ls = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        if (restart) begin
            m_mode = 0; m_rst_enter = n; m_fails = 0;
        end else begin
            case (m_mode)
                0: if (n - m_rst_enter >= RST_C) begin
                       m_mode = 1; m_wait_start = n; m_run = 0;
                   end
                1, 2: begin
                    expired = (n - m_wait_start) >= TO;
                    if (ls) m_run++; else m_run = 0;
                    if (m_run >= STB) begin
                        m_mode = 3; m_fails = 0;
                    end else if (m_mode == 1 && ls) begin
                        m_mode = 2;
                    end else if (m_mode == 2 && !ls) begin
                        m_mode = 1;
                    end else if (expired) begin
                        m_fails++;
                        if (m_fails >= MR) m_mode = 4;
                        else begin m_mode = 0; m_rst_enter = n; end
                    end
                end
                3: if (!ls) begin
                       m_mode = 0; m_rst_enter = n;
                       if (m_losses < 255) m_losses++;
                   end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [14:0] exp_vec();
        logic [2:0] st;
        logic [7:0] lc;
        st = 3'(m_mode);
        lc = 8'(m_losses);
        return {(m_mode == 0 || m_mode == 4), (m_mode == 3), (m_mode == 3), (m_mode == 4), st, lc};
    endfunction

    task automatic tick();
        @(posedge refclk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, RESET_VEC); end
        repeat (3) tick();
        checks++;
        if (obs !== RESET_VEC) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, RESET_VEC); end
        model_reset();
    endtask

    task automatic test_bringup();
        int k;
        rst_n = 1'b1;
        k = 0;
        do begin
            tick(); k++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL bringup_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end while (pll_rst && k < 20);
        checks++;
        if (k != RST_C) begin errors++; $display("FAIL bringup_rst_width: got %0d expected %0d", k, RST_C); end
        repeat (10) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL bringup_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
        pll_locked = 1'b1;
        k = 0;
        do begin
            tick(); k++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL bringup_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end while (!codec_rst_n && k < 50);
        checks++;
        if (k != 10) begin errors++; $display("FAIL bringup_lock_latency: got %0d expected 10", k); end
        checks++;
        if ({codec_rst_n, clk_ok, state} !== 5'b11011) begin
            errors++; $display("FAIL bringup_run: got %b expected 11011", {codec_rst_n, clk_ok, state});
        end
    endtask

    task automatic test_lock_loss();
        int fall_at, rst_hi;
        fall_at = 0; rst_hi = 0;
        pll_locked = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL loss_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
            if (!clk_ok && fall_at == 0) fall_at = i;
            if (pll_rst) rst_hi++;
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL loss_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
            if (pll_rst) rst_hi++;
        end
        checks++;
        if (fall_at != 3) begin errors++; $display("FAIL loss_clk_ok_fall: got %0d expected 3", fall_at); end
        checks++;
        if (rst_hi != RST_C) begin errors++; $display("FAIL loss_pll_rst_width: got %0d expected %0d", rst_hi, RST_C); end
        checks++;
        if (loss_count !== 8'd1) begin errors++; $display("FAIL loss_count: got %0d expected 1", loss_count); end
        checks++;
        if ({clk_ok, state} !== 4'b1011) begin errors++; $display("FAIL loss_rerun: got %b expected 1011", {clk_ok, state}); end
    endtask

    task automatic test_timeout_fault();
        int k, lo1, hi, lo2, bad;
        pll_locked = 1'b0;
        k = 0;
        while (!pll_rst && k < 10) begin
            tick(); k++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL tmo_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
        k = 0;
        while (pll_rst && k < 20) begin
            tick(); k++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL tmo_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
        lo1 = 0;
        while (!pll_rst && lo1 < 200) begin
            tick(); lo1++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL tmo_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
        hi = 0;
        while (pll_rst && !fault && hi < 20) begin
            tick(); hi++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL tmo_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
        lo2 = 0;
        while (!pll_rst && lo2 < 200) begin
            tick(); lo2++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL tmo_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
        checks++;
        if (lo1 != TO) begin errors++; $display("FAIL tmo_first: got %0d expected %0d", lo1, TO); end
        checks++;
        if (hi != RST_C) begin errors++; $display("FAIL tmo_rst_pulse: got %0d expected %0d", hi, RST_C); end
        checks++;
        if (lo2 != TO) begin errors++; $display("FAIL tmo_second: got %0d expected %0d", lo2, TO); end
        checks++;
        if ({pll_rst, fault, state} !== 5'b11100) begin errors++; $display("FAIL tmo_fault_entry: got %b expected 11100", {pll_rst, fault, state}); end
        bad = 0;
        repeat (1000) begin
            tick();
            if (!pll_rst || !fault || state !== 3'd4) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL tmo_fault_hold: got %0d bad cycles expected 0", bad); end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if ({pll_rst, fault, state} !== 5'b10000) begin errors++; $display("FAIL tmo_restart: got %b expected 10000", {pll_rst, fault, state}); end
        k = 0;
        while (pll_rst && k < 20) begin tick(); k++; end
        k = 0;
        while (!pll_rst && k < 200) begin
            tick(); k++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL tmo_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
        checks++;
        if ({fault, state} !== 4'b0000) begin errors++; $display("FAIL tmo_budget_restored: got %b expected 0000", {fault, state}); end
    endtask

    task automatic test_chatter();
        int k, lo;
        bit saw_run, saw_stable;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        k = 0;
        while (pll_rst && k < 20) begin tick(); k++; end
        pll_locked = 1'b1;
        lo = 0; saw_run = 0; saw_stable = 0;
        while (!pll_rst && lo < 200) begin
            tick(); lo++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL chatter_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
            if (clk_ok) saw_run = 1;
            if (state == 3'd2) saw_stable = 1;
            if (lo % 5 == 0) pll_locked = ~pll_locked;
        end
        checks++;
        if (lo != TO) begin errors++; $display("FAIL chatter_timeout: got %0d expected %0d", lo, TO); end
        checks++;
        if (saw_run || !saw_stable) begin errors++; $display("FAIL chatter_path: got run=%0d stable=%0d expected run=0 stable=1", saw_run, saw_stable); end
        pll_locked = 1'b1;
        k = 0;
        while (!clk_ok && k < 200) begin
            tick(); k++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL chatter_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
    endtask

    task automatic test_saturation_priority();
        int k;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            k = 0;
            while (clk_ok && k < 10) begin
                tick(); k++;
                checks++;
                if (obs !== exp_vec()) begin errors++; $display("FAIL sat_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
            end
            pll_locked = 1'b1;
            k = 0;
            while (!clk_ok && k < 100) begin
                tick(); k++;
                checks++;
                if (obs !== exp_vec()) begin errors++; $display("FAIL sat_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
            end
        end
        checks++;
        if (loss_count !== 8'd255) begin errors++; $display("FAIL sat_loss_count: got %0d expected 255", loss_count); end
        pll_locked = 1'b0;
        k = 0;
        while (state !== 3'd1 && k < 20) begin tick(); k++; end
        pll_locked = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL prio_setup: got %0d expected 1", state); end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL prio_restart_wins: got %0d expected 0", state); end
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL prio_model: got %h expected %h", obs, exp_vec()); end
    endtask

    task automatic test_async_reset();
        int k;
        pll_locked = 1'b1;
        k = 0;
        while (!clk_ok && k < 200) begin tick(); k++; end
        checks++;
        if (!clk_ok) begin errors++; $display("FAIL arst_setup: got clk_ok=%b expected 1", clk_ok); end
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin errors++; $display("FAIL arst_immediate: got %h expected %h", obs, RESET_VEC); end
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL arst_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                pll_locked = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 30);
            end
            hold--;
            restart = ($urandom_range(0, 63) == 0);
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random_model: got %h expected %h cyc %0d", obs, exp_vec(), m_cyc); end
        end
        restart = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bringup();
        test_lock_loss();
        test_timeout_fault();
        test_chatter();
        test_saturation_priority();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
